// File: rtl/nand_tile_pkg.sv
// Shared constants for the NAND tile: channel indices, channel count, glitch counter width,
// and the debounce counter width rule.
package nand_tile_pkg;

    localparam int CH_A     = 0;
    localparam int CH_B     = 1;
    localparam int NUM_CH   = 2;
    localparam int GLITCH_W = 8;

    // Width needed to hold 0..cycles-1, never less than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/nand_debounce_ch.sv
// One pad channel: synchroniser chain, debounce counter, clean level flop, registered
// edge strobes and a combinational "aborted change" flag for the glitch counter.
module nand_debounce_ch
    import nand_tile_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_out,
    output logic fall_out,
    output logic glitch_out
);

    localparam int                     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Final stage resets to the clean level so no change is seen right after reset.
    localparam logic [SYNC_STAGES-1:0] SYNC_RST = {RESET_VAL, {(SYNC_STAGES-1){1'b0}}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   glitch;
    logic                   synced;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        glitch  = 1'b0;
        if (ena) begin
            if (synced != clean_q) begin
                if (cnt_q == CNT_MAX) begin
                    clean_d = synced;
                    cnt_d   = '0;
                    rise_d  = synced;
                    fall_d  = ~synced;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (cnt_q != '0) begin
                cnt_d  = '0;
                glitch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= SYNC_RST;
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign glitch_out = glitch;

endmodule

// File: rtl/nand_input_conditioner.sv
// Conditions the two raw NAND input pads (A, B) into clean debounced levels with edge
// strobes, and keeps a saturating count of rejected glitches across both channels.
module nand_input_conditioner
    import nand_tile_pkg::*;
#(
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL       = 2'b00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_CH-1:0]   raw_in,
    output logic [NUM_CH-1:0]   clean_out,
    output logic [NUM_CH-1:0]   rise_out,
    output logic [NUM_CH-1:0]   fall_out,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    logic [NUM_CH-1:0]   glitch;
    logic [1:0]          glitch_inc;
    logic [GLITCH_W:0]   glitch_sum;
    logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;

    nand_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (RESET_VAL[CH_A])
    ) u_ch_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_in     (raw_in[CH_A]),
        .clean_out  (clean_out[CH_A]),
        .rise_out   (rise_out[CH_A]),
        .fall_out   (fall_out[CH_A]),
        .glitch_out (glitch[CH_A])
    );

    nand_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (RESET_VAL[CH_B])
    ) u_ch_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_in     (raw_in[CH_B]),
        .clean_out  (clean_out[CH_B]),
        .rise_out   (rise_out[CH_B]),
        .fall_out   (fall_out[CH_B]),
        .glitch_out (glitch[CH_B])
    );

    // Both channels may abort on the same edge, so the increment is 0, 1 or 2.
    assign glitch_inc = {1'b0, glitch[CH_A]} + {1'b0, glitch[CH_B]};
    assign glitch_sum = {1'b0, glitch_cnt_q} + {{(GLITCH_W-1){1'b0}}, glitch_inc};

    always_comb begin
        glitch_cnt_d = glitch_sum[GLITCH_W-1:0];
        if (glitch_sum[GLITCH_W]) begin
            glitch_cnt_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_nand_input_conditioner.sv
// Directed bench for nand_input_conditioner: edge pulses are checked by a monitor against
// an expected queue of {cycle, clean, rise, fall}; levels and glitch counts are checked inline.
module tb_nand_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] raw_in;
    logic [1:0] clean_out;
    logic [1:0] rise_out;
    logic [1:0] fall_out;
    logic [7:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected pulse record: {cycle[15:0], clean[1:0], rise[1:0], fall[1:0]}
    logic [21:0] exp_q[$];

    nand_input_conditioner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_out   (rise_out),
        .fall_out   (fall_out),
        .glitch_cnt (glitch_cnt)
    );

    // Clock and cycle count: cyc = number of rising edges seen so far.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [21:0] pack(input int c, input logic [1:0] cl,
                                         input logic [1:0] r, input logic [1:0] f);
        logic [31:0] cw;
        cw = 32'(c);
        return {cw[15:0], cl, r, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe the DUT presents must match the head of the expected queue.
    always @(negedge clk) begin
        logic [21:0] e;
        if (rst_n && ((rise_out | fall_out) != 2'b00)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=rise:%b fall:%b cyc:%0d required=none",
                         rise_out, fall_out, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e[21:6]));
                chk("pulse_clean", 32'(clean_out), 32'(e[5:4]));
                chk("pulse_rise",  32'(rise_out),  32'(e[3:2]));
                chk("pulse_fall",  32'(fall_out),  32'(e[1:0]));
            end
        end
    end

    initial begin
        int t0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        raw_in = 2'b11;

        // Reset held with pads toggling: everything stays at reset values.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            raw_in = (i % 2 == 0) ? 2'b00 : 2'b11;
            chk("rst_clean",  32'(clean_out),  32'h0);
            chk("rst_rise",   32'(rise_out),   32'h0);
            chk("rst_fall",   32'(fall_out),   32'h0);
            chk("rst_glitch", 32'(glitch_cnt), 32'h0);
        end
        raw_in = 2'b00;
        rst_n  = 1'b1;
        step(4);

        // Clean step on A: accepted after edge 6, rise pulse the same cycle.
        raw_in = 2'b01;
        t0 = cyc;
        exp_q.push_back(pack(t0 + 6, 2'b01, 2'b01, 2'b00));
        step(5);
        chk("step_before", 32'(clean_out), 32'h0);
        step(1);
        chk("step_after", 32'(clean_out), 32'h1);
        step(4);

        // A back low: fall pulse.
        raw_in = 2'b00;
        t0 = cyc;
        exp_q.push_back(pack(t0 + 6, 2'b00, 2'b00, 2'b01));
        step(8);
        chk("fall_level", 32'(clean_out), 32'h0);

        // Glitch on A: high for 3 sampled edges, rejected.
        raw_in = 2'b01;
        step(3);
        raw_in = 2'b00;
        step(5);
        chk("glitch_clean", 32'(clean_out),  32'h0);
        chk("glitch_count", 32'(glitch_cnt), 32'h1);

        // B rising, frozen by ena=0 after 2 compare edges, accepted 2 enabled edges later.
        raw_in = 2'b10;
        t0 = cyc;
        step(4);
        ena = 1'b0;
        step(10);
        chk("ena_hold_clean",  32'(clean_out),  32'h0);
        chk("ena_hold_glitch", 32'(glitch_cnt), 32'h1);
        ena = 1'b1;
        exp_q.push_back(pack(t0 + 16, 2'b10, 2'b10, 2'b00));
        step(1);
        chk("ena_resume_1", 32'(clean_out), 32'h0);
        step(1);
        chk("ena_resume_2", 32'(clean_out), 32'h2);
        step(4);

        raw_in = 2'b00;
        t0 = cyc;
        exp_q.push_back(pack(t0 + 6, 2'b00, 2'b00, 2'b10));
        step(8);

        // Async reset in the middle of a B rising count.
        raw_in = 2'b10;
        step(4);
        chk("pre_rst_glitch", 32'(glitch_cnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_clean",  32'(clean_out),  32'h0);
        chk("async_glitch", 32'(glitch_cnt), 32'h0);
        chk("async_rise",   32'(rise_out),   32'h0);
        raw_in = 2'b00;
        step(3);
        rst_n = 1'b1;
        step(12);
        chk("post_rst_clean",  32'(clean_out),  32'h0);
        chk("post_rst_glitch", 32'(glitch_cnt), 32'h0);

        // Aligned glitches on both channels: +2 per round, saturating at 8'hFF.
        for (int k = 1; k <= 130; k++) begin
            raw_in = 2'b11;
            step(3);
            raw_in = 2'b00;
            step(5);
            chk("sat_glitch", 32'(glitch_cnt), (2 * k > 255) ? 32'd255 : 32'(2 * k));
        end
        chk("sat_clean", 32'(clean_out), 32'h0);

        step(4);
        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
